// File: rtl/mips_pkg.sv
// Shared types and widths for the register-file write arbiter.
// Holds the LLU queue entry layout and the drain FSM states.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } llu_wr_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [REG_ADDR_W-1:0] r
    );
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Write-port bundle: WB request, LLU handshake, register-file side.
// The arbiter takes the slave view; its environment takes the master view.
interface wb_write_arbiter_if;
    import mips_pkg::*;

    logic [DATA_W-1:0]     i_wb_write_data;
    logic [REG_ADDR_W-1:0] i_wb_write_register;
    logic                  i_wb_reg_write;
    logic                  i_llu_valid;
    logic                  o_llu_ready;
    logic [DATA_W-1:0]     i_llu_data;
    logic [REG_ADDR_W-1:0] i_llu_register;
    logic [DATA_W-1:0]     o_rf_write_data;
    logic [REG_ADDR_W-1:0] o_rf_write_register;
    logic                  o_rf_reg_write;
    logic [NUM_REGS-1:0]   o_busy_regs;
    logic                  o_stall_req;
    logic                  o_order_err;

    modport slave (
        input  i_wb_write_data, i_wb_write_register, i_wb_reg_write,
        input  i_llu_valid, i_llu_data, i_llu_register,
        output o_llu_ready,
        output o_rf_write_data, o_rf_write_register, o_rf_reg_write,
        output o_busy_regs, o_stall_req, o_order_err
    );

    modport master (
        output i_wb_write_data, i_wb_write_register, i_wb_reg_write,
        output i_llu_valid, i_llu_data, i_llu_register,
        input  o_llu_ready,
        input  o_rf_write_data, o_rf_write_register, o_rf_reg_write,
        input  o_busy_regs, o_stall_req, o_order_err
    );

endinterface

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO with per-slot valid bits and a tag view
// of every slot (top TAG_W bits) for decoding what is in flight.
module wb_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH-1:0][TAG_W-1:0] ent_tag
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            vld;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = &vld;
    assign empty   = ~|vld;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Push and pop never hit the same slot: that needs full or empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata     = mem[rd_ptr];
    assign ent_valid = vld;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_tag[i] = mem[i][WIDTH-1 -: TAG_W];
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: WB passes through, LLU results
// queue and drain into idle WB cycles, with a starvation drain mode.
module wb_write_arbiter
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    wb_write_arbiter_if.slave  bus
);

    localparam int CW  = $clog2(STARVE_LIMIT + 1);
    localparam int EW  = $bits(llu_wr_t);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic                                 wb_eff;
    logic                                 push;
    logic                                 pop;
    logic                                 full;
    logic                                 empty;
    llu_wr_t                              in_ent;
    llu_wr_t                              head;
    logic [FIFO_DEPTH-1:0]                ent_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic [NUM_REGS-1:0]                  busy;
    logic [CW-1:0]                        cnt;
    arb_state_t                           state;
    logic                                 err;

    // Writes to r0 are idle cycles; reset also blanks the port.
    assign wb_eff = reset && bus.i_wb_reg_write &&
                    (bus.i_wb_write_register != '0);

    assign bus.o_llu_ready = reset && !full;
    assign push = bus.i_llu_valid && bus.o_llu_ready &&
                  (bus.i_llu_register != '0);
    assign pop  = !wb_eff && !empty;

    assign in_ent = {bus.i_llu_register, bus.i_llu_data};

    wb_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .TAG_W (REG_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wdata     (in_ent),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .ent_valid (ent_vld),
        .ent_tag   (ent_rd)
    );

    always_comb begin
        bus.o_rf_reg_write      = 1'b0;
        bus.o_rf_write_register = '0;
        bus.o_rf_write_data     = '0;
        unique case (1'b1)
            wb_eff: begin
                bus.o_rf_reg_write      = 1'b1;
                bus.o_rf_write_register = bus.i_wb_write_register;
                bus.o_rf_write_data     = bus.i_wb_write_data;
            end
            pop: begin
                bus.o_rf_reg_write      = 1'b1;
                bus.o_rf_write_register = head.rd;
                bus.o_rf_write_data     = head.data;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (ent_vld[i]) busy = busy | reg_onehot(ent_rd[i]);
        busy[0] = 1'b0;
    end

    assign bus.o_busy_regs = busy;
    assign bus.o_stall_req = (state == DRAIN);
    assign bus.o_order_err = err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err   <= 1'b0;
            cnt   <= '0;
            state <= NORMAL;
        end else begin
            if (wb_eff && busy[bus.i_wb_write_register])
                err <= 1'b1;
            if (pop || empty)
                cnt <= '0;
            else if (wb_eff && cnt != LIMIT)
                cnt <= cnt + 1'b1;
            unique case (state)
                NORMAL:  if (cnt == LIMIT) state <= DRAIN;
                DRAIN:   if (empty) state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed table, drain/reset sequences
// and random traffic against a queue-based reference model.
module tb_wb_write_arbiter;
    import mips_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wb_write_arbiter_if bus();

    wb_write_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue of pending results plus counters.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          denied;
    bit          drain;
    bit          err;
    bit          m_wbeff;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    logic        m_rdy;

    function automatic void model_eval();
        m_busy = '0;
        foreach (q[i]) if (q[i].r != 0) m_busy[q[i].r] = 1'b1;
        m_rdy   = (q.size() < DEPTH);
        m_wbeff = bus.i_wb_reg_write && (bus.i_wb_write_register != 0);
        m_we    = 1'b0;
        m_reg   = '0;
        m_data  = '0;
        if (m_wbeff) begin
            m_we   = 1'b1;
            m_reg  = bus.i_wb_write_register;
            m_data = bus.i_wb_write_data;
        end else if (q.size() != 0) begin
            m_we   = 1'b1;
            m_reg  = q[0].r;
            m_data = q[0].d;
        end
    endfunction

    function automatic void model_commit();
        bit popped;
        bit was_empty;
        bit hit;
        ent_t e;
        popped    = !m_wbeff && (q.size() != 0);
        was_empty = (q.size() == 0);
        hit       = (denied == LIMIT);
        if (m_wbeff && m_busy[bus.i_wb_write_register]) err = 1'b1;
        if (popped) void'(q.pop_front());
        if (bus.i_llu_valid && m_rdy && bus.i_llu_register != 0) begin
            e.r = bus.i_llu_register;
            e.d = bus.i_llu_data;
            q.push_back(e);
        end
        if (popped || was_empty) denied = 0;
        else if (m_wbeff && denied < LIMIT) denied++;
        if (drain && was_empty) drain = 1'b0;
        else if (!drain && hit) drain = 1'b1;
    endfunction

    task automatic model_cmp();
        chk("m_we",    bus.o_rf_reg_write,      m_we);
        chk("m_reg",   bus.o_rf_write_register, m_reg);
        chk("m_data",  bus.o_rf_write_data,     m_data);
        chk("m_busy",  bus.o_busy_regs,         m_busy);
        chk("m_rdy",   bus.o_llu_ready,         m_rdy);
        chk("m_stall", bus.o_stall_req,         drain);
        chk("m_err",   bus.o_order_err,         err);
    endtask

    task automatic drive(input bit wb, input logic [4:0] wr,
                         input logic [31:0] wd, input bit lv,
                         input logic [4:0] lr, input logic [31:0] ld);
        bus.i_wb_reg_write      = wb;
        bus.i_wb_write_register = wr;
        bus.i_wb_write_data     = wd;
        bus.i_llu_valid         = lv;
        bus.i_llu_register      = lr;
        bus.i_llu_data          = ld;
    endtask

    task automatic pre();
        @(negedge clk);
        model_eval();
        model_cmp();
    endtask

    task automatic post();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Assert reset with live requests; every output must drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1, 5'd1, 32'hFFFF, 1, 5'd2, 32'h5);
        #1;
        chk("rst_we",    bus.o_rf_reg_write,      0);
        chk("rst_reg",   bus.o_rf_write_register, 0);
        chk("rst_data",  bus.o_rf_write_data,     0);
        chk("rst_busy",  bus.o_busy_regs,         0);
        chk("rst_rdy",   bus.o_llu_ready,         0);
        chk("rst_stall", bus.o_stall_req,         0);
        chk("rst_err",   bus.o_order_err,         0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        q.delete();
        denied = 0;
        drain  = 1'b0;
        err    = 1'b0;
        rst_n  = 1'b1;
    endtask

    typedef struct {
        bit          wb;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        bit          e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        bit          e_rdy;
        bit          e_err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // wb wr wd | lv lr ld | we reg data | busy rdy err
        tbl[0]  = '{0, 0, 0,      1, 5, 'h11, 0, 0, 0,      0,     1, 0};
        tbl[1]  = '{0, 0, 0,      0, 0, 0,    1, 5, 'h11,   'h20,  1, 0};
        tbl[2]  = '{0, 0, 0,      0, 0, 0,    0, 0, 0,      0,     1, 0};
        tbl[3]  = '{1, 1, 'hA1,   1, 3, 'h33, 1, 1, 'hA1,   0,     1, 0};
        tbl[4]  = '{1, 1, 'hA2,   1, 4, 'h44, 1, 1, 'hA2,   'h8,   1, 0};
        tbl[5]  = '{1, 2, 'hA3,   1, 7, 'h77, 1, 2, 'hA3,   'h18,  0, 0};
        tbl[6]  = '{0, 0, 0,      1, 7, 'h77, 1, 3, 'h33,   'h18,  0, 0};
        tbl[7]  = '{0, 0, 0,      1, 7, 'h77, 1, 4, 'h44,   'h10,  1, 0};
        tbl[8]  = '{1, 0, 'hDEAD, 0, 0, 0,    1, 7, 'h77,   'h80,  1, 0};
        tbl[9]  = '{0, 0, 0,      1, 0, 'h99, 0, 0, 0,      0,     1, 0};
        tbl[10] = '{0, 0, 0,      0, 0, 0,    0, 0, 0,      0,     1, 0};
        tbl[11] = '{0, 0, 0,      1, 9, 'h90, 0, 0, 0,      0,     1, 0};
        tbl[12] = '{1, 9, 'hB9,   0, 0, 0,    1, 9, 'hB9,   'h200, 1, 0};
        tbl[13] = '{1, 8, 'hB8,   0, 0, 0,    1, 8, 'hB8,   'h200, 1, 1};
        tbl[14] = '{0, 0, 0,      0, 0, 0,    1, 9, 'h90,   'h200, 1, 1};
        tbl[15] = '{0, 0, 0,      0, 0, 0,    0, 0, 0,      0,     1, 1};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].wb, tbl[i].wr, tbl[i].wd,
                  tbl[i].lv, tbl[i].lr, tbl[i].ld);
            pre();
            chk($sformatf("t%0d_we", i),   bus.o_rf_reg_write,
                tbl[i].e_we);
            chk($sformatf("t%0d_reg", i),  bus.o_rf_write_register,
                tbl[i].e_reg);
            chk($sformatf("t%0d_data", i), bus.o_rf_write_data,
                tbl[i].e_data);
            chk($sformatf("t%0d_busy", i), bus.o_busy_regs,
                tbl[i].e_busy);
            chk($sformatf("t%0d_rdy", i),  bus.o_llu_ready,
                tbl[i].e_rdy);
            chk($sformatf("t%0d_err", i),  bus.o_order_err,
                tbl[i].e_err);
            post();
        end

        // Starvation: one queued entry, WB busy every cycle.
        do_reset();
        drive(1, 5'd1, 32'h100, 1, 5'd12, 32'hC);
        pre();
        post();
        for (int d = 1; d <= 10; d++) begin
            drive(1, 5'd1, 32'(d), 0, 0, 0);
            pre();
            chk($sformatf("starve_stall_d%0d", d), bus.o_stall_req,
                (d == 10) ? 1 : 0);
            post();
        end
        drive(0, 0, 0, 0, 0, 0);
        pre();
        chk("drain_we",    bus.o_rf_reg_write,      1);
        chk("drain_reg",   bus.o_rf_write_register, 12);
        chk("drain_data",  bus.o_rf_write_data,     'hC);
        chk("drain_stall", bus.o_stall_req,         1);
        post();
        pre();
        chk("drain_hold", bus.o_stall_req, 1);
        chk("drain_busy", bus.o_busy_regs, 0);
        post();
        pre();
        chk("drain_drop", bus.o_stall_req, 0);
        post();

        // Reset while draining with two entries queued.
        do_reset();
        drive(1, 5'd1, 32'h1, 1, 5'd12, 32'hC0);
        pre();
        post();
        drive(1, 5'd1, 32'h2, 1, 5'd13, 32'hD0);
        pre();
        post();
        drive(1, 5'd1, 32'h3, 0, 0, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                pre();
                seen = bus.o_stall_req;
                post();
            end
            chk("mid_drain_reached", seen, 1);
        end
        chk("mid_drain_busy", bus.o_busy_regs, 32'h3000);
        do_reset();
        pre();
        chk("after_rst_rdy",  bus.o_llu_ready, 1);
        chk("after_rst_busy", bus.o_busy_regs, 0);
        chk("after_rst_we",   bus.o_rf_reg_write, 0);
        post();

        // Random traffic; hazard unit mostly idles WB during drain.
        for (int c = 0; c < 3000; c++) begin
            bit wb;
            if (c % 500 == 499) do_reset();
            if (drain) wb = ($urandom_range(3) == 0);
            else       wb = ($urandom_range(9) < 8);
            drive(wb, 5'($urandom_range(15)), $urandom(),
                  ($urandom_range(2) != 0), 5'($urandom_range(15)),
                  $urandom());
            pre();
            post();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
